// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes, status flags and one-bit-per-cycle shifts.
// Define ALU_MUL_EN to build the iterative shift-and-add multiplier (sel=10); otherwise sel=10 is illegal.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [4:0]       flags
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif

  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [4:0]       flags_q, flags_d;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
`endif

  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             is_iter;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic             sc_ovf;
  logic             sc_err;
  logic [WIDTH-1:0] sh_next;
  logic             sh_bit;
  logic [WIDTH-1:0] it_res;
  logic             it_carry;

  assign shamt     = b[SHW-1:0];
  assign is_shift  = (sel == OP_SLL) || (sel == OP_SRL) || (sel == OP_SRA);
`ifdef ALU_MUL_EN
  assign is_iter   = (is_shift && (shamt != '0)) || (sel == OP_MUL);
`else
  assign is_iter   = is_shift && (shamt != '0);
`endif
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign flags     = flags_q;

  // Single-cycle datapath; a zero-amount shift simply passes a through with carry 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_err   = 1'b0;
    case (sel)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_ADD: begin
        sc_res   = sum_ext[WIDTH-1:0];
        sc_carry = sum_ext[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = diff_ext[WIDTH-1:0];
        sc_carry = diff_ext[WIDTH];
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL, OP_SRL, OP_SRA: sc_res = a;
      default: sc_err = 1'b1;
    endcase
  end

  // One shift step on the working register, plus the bit that falls off.
  always_comb begin
    sh_bit  = 1'b0;
    sh_next = work_q;
    case (op_q)
      OP_SLL: begin
        sh_bit  = work_q[WIDTH-1];
        sh_next = {work_q[WIDTH-2:0], 1'b0};
      end
      OP_SRL: begin
        sh_bit  = work_q[0];
        sh_next = {1'b0, work_q[WIDTH-1:1]};
      end
      OP_SRA: begin
        sh_bit  = work_q[0];
        sh_next = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    flags_d  = flags_q;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
    mplr_d   = mplr_q;
`endif
    it_res   = '0;
    it_carry = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d   = sel;
          work_d = a;
          cnt_d  = {1'b0, shamt};
          if (is_iter) begin
            state_d = BUSY;
`ifdef ALU_MUL_EN
            acc_d  = '0;
            mplr_d = b;
            if (sel == OP_MUL) cnt_d = (SHW+1)'(WIDTH);
`endif
          end else begin
            state_d = DONE;
            out_d   = sc_res;
            flags_d = {sc_err, sc_res[WIDTH-1], sc_ovf, sc_carry, (sc_res == '0)};
          end
        end
      end
      BUSY: begin
        cnt_d    = cnt_q - CNT_ONE;
        work_d   = sh_next;
        it_res   = sh_next;
        it_carry = sh_bit;
`ifdef ALU_MUL_EN
        // Multiplicand walks left while multiplier bits are consumed from the bottom.
        if (op_q == OP_MUL) begin
          work_d   = work_q << 1;
          mplr_d   = mplr_q >> 1;
          acc_d    = mplr_q[0] ? (acc_q + work_q) : acc_q;
          it_res   = acc_d;
          it_carry = 1'b0;
        end
`endif
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
          out_d   = it_res;
          flags_d = {1'b0, it_res[WIDTH-1], 1'b0, it_carry, (it_res == '0)};
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      flags_q <= '0;
`ifdef ALU_MUL_EN
      acc_q   <= '0;
      mplr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      flags_q <= flags_d;
`ifdef ALU_MUL_EN
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checks of alu_mc against an arithmetic reference model.
// Honours ALU_MUL_EN the same way the RTL does.
module tb_alu_mc;
  localparam int W = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [4:0]   flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic per op; latency in cycles from the accept edge.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t        m;
    logic [31:0] r;
    logic        c, v, e;
    longint      sx, sy, s;
    logic [63:0] w;
    int          sh;
    sh = int'(y[4:0]);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    m.lat = 1;
    case (op)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: r = x ^ y;
      4'd3: begin
        w = {32'd0, x} + {32'd0, y};
        r = w[31:0];
        c = (w >= 64'h1_0000_0000);
        s = sx + sy;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4: begin
        r = x - y;
        c = (x >= y);
        s = sx - sy;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd5: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd6: r = (x < y) ? 32'd1 : 32'd0;
      4'd7: begin
        w = {32'd0, x} << sh;
        r = w[31:0];
        c = (sh != 0) && w[32];
        m.lat = sh + 1;
      end
      4'd8: begin
        r = x >> sh;
        c = (sh != 0) && x[(sh == 0) ? 0 : sh-1];
        m.lat = sh + 1;
      end
      4'd9: begin
        r = 32'(sx >>> sh);
        c = (sh != 0) && x[(sh == 0) ? 0 : sh-1];
        m.lat = sh + 1;
      end
      4'd10: begin
        if (MUL_EN) begin
          w = {32'd0, x} * {32'd0, y};
          r = w[31:0];
          m.lat = W + 1;
        end else begin
          e = 1'b1;
        end
      end
      default: e = 1'b1;
    endcase
    m.res = r;
    m.fl  = {e, r[31], v, c, (r == 32'd0)};
    return m;
  endfunction

  // Issue one transaction, hold back-pressure for 'stall' cycles, then drain to IDLE.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input int stall);
    exp_t e;
    int   lat;
    e = model(op, x, y);
    check({name, ":in_ready"}, 64'(in_ready), 64'd1);
    a = x; b = y; sel = op; in_valid = 1'b1;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sel = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({name, ":latency"}, 64'(lat), 64'(e.lat));
    check({name, ":out"}, 64'(out), 64'(e.res));
    check({name, ":flags"}, 64'(flags), 64'(e.fl));
    for (int i = 0; i < stall; i++) begin
      tick();
      check({name, ":stall"}, {out_valid, in_ready, flags, out}, {1'b1, 1'b0, e.fl, e.res});
    end
    out_ready = 1'b1;
    tick();
    check({name, ":drain"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int   accepts;
    int   seen;
    logic [3:0]  rop;
    logic [31:0] rx, ry;

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    a = 32'h1234_5678; b = 32'h1; sel = 4'd3;
    repeat (3) tick();
    check("rst:out_valid", 64'(out_valid), 64'd0);
    check("rst:in_ready", 64'(in_ready), 64'd0);
    check("rst:out", 64'(out), 64'd0);
    check("rst:flags", 64'(flags), 64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    check("rst:release", {out_valid, in_ready}, 2'b01);

    do_op("and", 4'd0, 32'hF0F0_00FF, 32'h0FF0_FF0F, 3);
    do_op("or",  4'd1, 32'hF0F0_00FF, 32'h0FF0_FF0F, 3);
    do_op("xor", 4'd2, 32'hF0F0_00FF, 32'h0FF0_FF0F, 0);
    check("xor:value", 64'(out), 64'hFF00_FFF0);

    do_op("add_ovf",   4'd3, 32'h7FFF_FFFF, 32'h1, 0);
    check("add_ovf:value", {out, flags}, {32'h8000_0000, 5'b01100});
    do_op("add_carry", 4'd3, 32'hFFFF_FFFF, 32'h1, 1);
    check("add_carry:value", {out, flags}, {32'h0, 5'b00011});
    do_op("sub_neg",   4'd4, 32'd5, 32'd7, 0);
    check("sub_neg:value", {out, flags[1]}, {32'hFFFF_FFFE, 1'b0});
    do_op("slt",  4'd5, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 0);

    do_op("sra31", 4'd9, 32'h8000_0000, 32'd31, 2);
    check("sra31:value", 64'(out), 64'hFFFF_FFFF);
    do_op("sll0",  4'd7, 32'h1, 32'h0, 0);
    check("sll0:value", 64'(out), 64'd1);
    do_op("srl1",  4'd8, 32'h3, 32'h1, 0);
    check("srl1:value", {out, flags[1]}, {32'd1, 1'b1});
    do_op("sll31", 4'd7, 32'h0000_0003, 32'hFFFF_FFFF, 0);

    do_op("mul", 4'd10, 32'h0001_0003, 32'h0000_0005, 1);
    do_op("illegal13", 4'd13, 32'hDEAD_BEEF, 32'h1, 0);
    check("illegal13:value", {out, flags}, {32'h0, 5'b10001});

    // Back-to-back single-cycle ops with out_ready tied high: one accept every 2 cycles.
    a = 32'd1; b = 32'd2; sel = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) accepts++;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("throughput:accepts", 64'(accepts), 64'd5);
    check("throughput:idle", {out_valid, in_ready}, 2'b01);

    // Reset ten cycles into a multiply must lose the result.
    a = 32'h0001_0003; b = 32'h5; sel = 4'd10; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    check("midrst:state", {out_valid, in_ready, out, flags}, 39'd0);
    rst_n = 1'b1;
    #1;
    check("midrst:in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("midrst:no_valid", 64'(seen), 64'd0);
    do_op("post_rst_add", 4'd3, 32'd2, 32'd3, 0);
    check("post_rst_add:value", 64'(out), 64'd5);

    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      rx  = $urandom;
      ry  = $urandom;
      case ($urandom_range(0, 3))
        0: ry[4:0] = 5'd0;
        1: ry[4:0] = 5'd31;
        default: ;
      endcase
      do_op($sformatf("rand%0d_op%0d", n, rop), rop, rx, ry, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
